// File: rtl/id_stage_pipelined_pkg.sv
// Shared ARM decode definitions: control word layout, ALU command codes,
// condition codes, instruction modes and the condition evaluator.
package arm_pkg;

  localparam int CTRL_W    = 9;
  localparam int CTRL_WB   = 8;
  localparam int CTRL_MEMW = 7;
  localparam int CTRL_MEMR = 6;
  localparam int CTRL_BR   = 5;
  localparam int CTRL_S    = 4;

  typedef struct packed {
    logic       wb_en;
    logic       mem_w;
    logic       mem_r;
    logic       branch;
    logic       s;
    logic [3:0] exe_cmd;
  } ctrl_t;

  localparam logic [3:0] EXE_NOP = 4'b0000;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_MVN = 4'b1001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;

  // ARM data-processing opcodes as found in instr[24:21]
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;

  localparam logic [3:0] CC_EQ = 4'b0000;
  localparam logic [3:0] CC_NE = 4'b0001;
  localparam logic [3:0] CC_CS = 4'b0010;
  localparam logic [3:0] CC_CC = 4'b0011;
  localparam logic [3:0] CC_MI = 4'b0100;
  localparam logic [3:0] CC_PL = 4'b0101;
  localparam logic [3:0] CC_VS = 4'b0110;
  localparam logic [3:0] CC_VC = 4'b0111;
  localparam logic [3:0] CC_HI = 4'b1000;
  localparam logic [3:0] CC_LS = 4'b1001;
  localparam logic [3:0] CC_GE = 4'b1010;
  localparam logic [3:0] CC_LT = 4'b1011;
  localparam logic [3:0] CC_GT = 4'b1100;
  localparam logic [3:0] CC_LE = 4'b1101;
  localparam logic [3:0] CC_AL = 4'b1110;

  // nzcv = {N,Z,C,V}; the reserved code 1111 never executes
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      CC_EQ:   return z;
      CC_NE:   return ~z;
      CC_CS:   return c;
      CC_CC:   return ~c;
      CC_MI:   return n;
      CC_PL:   return ~n;
      CC_VS:   return v;
      CC_VC:   return ~v;
      CC_HI:   return c & ~z;
      CC_LS:   return ~c | z;
      CC_GE:   return n == v;
      CC_LT:   return n != v;
      CC_GT:   return ~z & (n == v);
      CC_LE:   return z | (n != v);
      CC_AL:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/id_stage_pipelined_if.sv
// Decode-stage bus: IF/ID slot, write-back and hazard sources in, ID/EX slot out.
interface id_stage_pipelined_if
  import arm_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 16
);
  localparam int RA_W = $clog2(REG_CNT);

  logic              in_valid;
  logic [DATA_W-1:0] pc_in;
  logic [31:0]       instruction;
  logic [3:0]        status_in;
  logic              flush;
  logic              wb_en;
  logic [RA_W-1:0]   wb_dest;
  logic [DATA_W-1:0] wb_value;
  logic              ex_wb_en;
  logic              ex_mem_r;
  logic [RA_W-1:0]   ex_dest;
  logic              mem_wb_en;
  logic [RA_W-1:0]   mem_dest;

  logic              hazard;
  logic              out_valid;
  logic [DATA_W-1:0] pc_out;
  logic [DATA_W-1:0] rn_val;
  logic [DATA_W-1:0] rm_val;
  logic [RA_W-1:0]   dest;
  logic [RA_W-1:0]   src1;
  logic [RA_W-1:0]   src2;
  logic              imm;
  logic [11:0]       shift_op;
  logic [23:0]       simm24;
  logic [CTRL_W-1:0] ctrl;
  logic [3:0]        status_out;

  modport master (
    output in_valid, pc_in, instruction, status_in, flush,
           wb_en, wb_dest, wb_value, ex_wb_en, ex_mem_r, ex_dest, mem_wb_en, mem_dest,
    input  hazard, out_valid, pc_out, rn_val, rm_val, dest, src1, src2,
           imm, shift_op, simm24, ctrl, status_out
  );

  modport slave (
    input  in_valid, pc_in, instruction, status_in, flush,
           wb_en, wb_dest, wb_value, ex_wb_en, ex_mem_r, ex_dest, mem_wb_en, mem_dest,
    output hazard, out_valid, pc_out, rn_val, rm_val, dest, src1, src2,
           imm, shift_op, simm24, ctrl, status_out
  );

endinterface

// File: rtl/id_stage_pipelined_reg_file_bypass.sv
// Two-read, one-write register file; a read of the register being written
// this cycle returns the incoming value.
module reg_file_bypass #(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 16,
  localparam int RA_W   = $clog2(REG_CNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [RA_W-1:0]   waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [RA_W-1:0]   raddr1,
  input  logic [RA_W-1:0]   raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs [REG_CNT];

  // reset wins over a write-back landing on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_CNT; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (we && waddr == raddr1) ? wdata : regs[raddr1];
  assign rdata2 = (we && waddr == raddr2) ? wdata : regs[raddr2];

endmodule

// File: rtl/id_stage_pipelined.sv
// ARM decode stage: decode, operand read with WB bypass, condition check,
// stall generation and the ID/EX pipeline register.
module id_stage_pipelined
  import arm_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 16,
  parameter int FWD_EN  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  id_stage_pipelined_if.slave  bus
);

  localparam int RA_W = $clog2(REG_CNT);

  logic [3:0]        cond, opcode;
  logic [1:0]        mode;
  logic              imm, s_bit, is_str, uses_rn, uses_src2;
  logic              cond_ok, ex_hit, mem_hit, load;
  logic [RA_W-1:0]   src1, src2, rd;
  logic [DATA_W-1:0] rn_rd, rm_rd;
  ctrl_t             dc;

  assign cond   = bus.instruction[31:28];
  assign mode   = bus.instruction[27:26];
  assign imm    = bus.instruction[25];
  assign opcode = bus.instruction[24:21];
  assign s_bit  = bus.instruction[20];
  assign is_str = (mode == MODE_MEM) & ~s_bit;
  assign src1   = RA_W'(bus.instruction[19:16]);
  assign rd     = RA_W'(bus.instruction[15:12]);
  assign src2   = is_str ? RA_W'(bus.instruction[15:12]) : RA_W'(bus.instruction[3:0]);

  assign uses_rn   = ~((mode == MODE_BR) |
                       ((mode == MODE_DP) & (opcode == OP_MOV || opcode == OP_MVN)));
  assign uses_src2 = ~imm | is_str;

  always_comb begin
    dc = '0;
    case (mode)
      MODE_DP: begin
        dc.s     = s_bit;
        dc.wb_en = ~(opcode == OP_CMP || opcode == OP_TST);
        case (opcode)
          OP_MOV:         dc.exe_cmd = EXE_MOV;
          OP_MVN:         dc.exe_cmd = EXE_MVN;
          OP_ADD:         dc.exe_cmd = EXE_ADD;
          OP_ADC:         dc.exe_cmd = EXE_ADC;
          OP_SUB, OP_CMP: dc.exe_cmd = EXE_SUB;
          OP_SBC:         dc.exe_cmd = EXE_SBC;
          OP_AND, OP_TST: dc.exe_cmd = EXE_AND;
          OP_ORR:         dc.exe_cmd = EXE_ORR;
          OP_EOR:         dc.exe_cmd = EXE_EOR;
          default:        dc.exe_cmd = EXE_NOP;
        endcase
      end
      MODE_MEM: begin
        dc.exe_cmd = EXE_ADD;
        dc.mem_r   = s_bit;
        dc.mem_w   = ~s_bit;
        dc.wb_en   = s_bit;
      end
      MODE_BR: dc.branch = 1'b1;
      default: dc = '0;
    endcase
  end

  assign cond_ok = cond_pass(cond, bus.status_in);

  // WB never stalls: the register file bypass covers it
  assign ex_hit  = bus.ex_wb_en &
                   ((uses_rn & (src1 == bus.ex_dest)) | (uses_src2 & (src2 == bus.ex_dest)));
  assign mem_hit = bus.mem_wb_en &
                   ((uses_rn & (src1 == bus.mem_dest)) | (uses_src2 & (src2 == bus.mem_dest)));
  assign bus.hazard = bus.in_valid &
                      ((FWD_EN != 0) ? (bus.ex_mem_r & ex_hit) : (ex_hit | mem_hit));

  assign load = bus.in_valid & ~bus.flush & ~bus.hazard;

  reg_file_bypass #(.DATA_W(DATA_W), .REG_CNT(REG_CNT)) u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (bus.wb_en),
    .waddr  (bus.wb_dest),
    .wdata  (bus.wb_value),
    .raddr1 (src1),
    .raddr2 (src2),
    .rdata1 (rn_rd),
    .rdata2 (rm_rd)
  );

  // Data fields load every cycle; only out_valid and ctrl carry the bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid  <= 1'b0;
      bus.ctrl       <= '0;
      bus.pc_out     <= '0;
      bus.rn_val     <= '0;
      bus.rm_val     <= '0;
      bus.dest       <= '0;
      bus.src1       <= '0;
      bus.src2       <= '0;
      bus.imm        <= 1'b0;
      bus.shift_op   <= '0;
      bus.simm24     <= '0;
      bus.status_out <= '0;
    end else begin
      bus.out_valid  <= load;
      bus.ctrl       <= (load & cond_ok) ? dc : '0;
      bus.pc_out     <= bus.pc_in;
      bus.rn_val     <= rn_rd;
      bus.rm_val     <= rm_rd;
      bus.dest       <= rd;
      bus.src1       <= src1;
      bus.src2       <= src2;
      bus.imm        <= imm;
      bus.shift_op   <= bus.instruction[11:0];
      bus.simm24     <= bus.instruction[23:0];
      bus.status_out <= bus.status_in;
    end
  end

endmodule

// File: doc/id_stage_pipelined.md
# id_stage_pipelined

Parametrised ARM decode stage with an integrated register file, hazard detection and the ID/EX pipeline register. It sits between the IF/ID register and the execute stage. Each cycle it decodes one instruction, reads operands with same-cycle write-back bypass, evaluates the condition field, and raises a stall toward fetch on data hazards. All EX-bound outputs are registered with bubble insertion on hazard, flush or condition failure.

## Interface
- DATA_W, 32, register/operand width
- REG_CNT, 16, register file depth; address width RA_W = $clog2(REG_CNT)
- FWD_EN, 0, 1 = forwarding exists downstream: stall only on load-use
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  IF/ID slot holds a real instruction
- pc_in  in  DATA_W  PC of instruction
- instruction  in  32  instruction word
- status_in  in  4  {N,Z,C,V} from status register
- flush  in  1  branch taken in EX; kill this slot
- wb_en / wb_dest / wb_value  in  1 / RA_W / DATA_W  write-back port
- ex_wb_en, ex_mem_r, ex_dest  in  1,1,RA_W  instruction currently in EX
- mem_wb_en, mem_dest  in  1,RA_W  instruction currently in MEM
- hazard  out  1  combinational stall request to PC and IF/ID
- out_valid  out  1  ID/EX slot valid
- pc_out, rn_val, rm_val  out  DATA_W  registered PC and operands
- dest, src1, src2  out  RA_W  Rd, Rn, second source
- imm  out  1  instruction[25]
- shift_op  out  12  instruction[11:0]
- simm24  out  24  instruction[23:0]
- ctrl  out  9  {wb_en, mem_w, mem_r, branch, s, exe_cmd[3:0]}
- status_out  out  4  status_in captured with the instruction

## Operation
- Decode: mode = instr[27:26], opcode = instr[24:21], S = instr[20]. Mode 00: data processing. Mode 01: LDR if S=1, STR if S=0, exe_cmd ADD. Mode 10: branch.
- exe_cmd map: MOV 0001, MVN 1001, ADD/LDR/STR 0010, ADC 0011, SUB/CMP 0100, SBC 0101, AND/TST 0110, ORR 0111, EOR 1000.
- wb_en is set for all data-processing ops except CMP/TST, and for LDR.
- src1 = instr[19:16]. src2 = instr[15:12] when STR, else instr[3:0].
- uses_rn is 0 for MOV, MVN and branch. uses_src2 = ~imm | STR.
- Register file: REG_CNT x DATA_W, written on clk edge when wb_en. A read whose address equals wb_dest while wb_en=1 returns wb_value (write-first bypass).
- Condition check on instr[31:28] vs status_in: EQ NE CS CC MI PL VS VC HI LS GE LT GT LE AL. Code 1111 fails.
- hazard requires in_valid and one of:
  - FWD_EN=0: (uses_rn & src1 match) or (uses_src2 & src2 match) against ex_dest with ex_wb_en, or mem_dest with mem_wb_en.
  - FWD_EN=1: the same test against EX only, gated by ex_mem_r.
- ID/EX load, priority high to low:
  - rst: all outputs 0.
  - flush: bubble.
  - hazard: bubble.
  - ~in_valid: bubble.
  - Condition fail: out_valid=1, ctrl=0, other fields loaded.
  - Otherwise: load all fields.
- Bubble = out_valid 0, ctrl 0, other fields don't-care. Register contents are unaffected.

## Timing
- Reset: the register file and every output register clear to 0 on the first edge with rst=1. This includes rst mid-stream; a pending write-back on that edge is discarded.
- Latency: 1 cycle from instruction to ID/EX outputs.
- hazard is combinational in the same cycle and does not depend on rst.
- Upstream holds the instruction while hazard=1. The stage re-evaluates every cycle and loads the instruction on the first cycle hazard=0.
- flush and hazard in the same cycle: flush wins; hazard is still driven.
- wb_dest equal to src1 in the same cycle: the new value is captured into rn_val and the register is written. No hazard arises from WB.

## Structure
- Shared package `arm_pkg`: ctrl bit indices, exe_cmd constants, condition-code constants, mode constants.
- One sub-module: `reg_file_bypass` (parametrised DATA_W/REG_CNT, two read ports, one write port, write-first).
- Decode, condition check and hazard logic are combinational in the top module; the ID/EX register is the only other state.

## Test plan
- rst=1 for 2 cycles: all outputs 0 and hazard=0. Afterward, reading R3 returns 0.
- ADD R1,R2,R3 (0xE0821003) with R2=5, R3=7 preloaded via WB: next cycle ctrl={1,0,0,0,0,0010}, rn_val=5, rm_val=7, dest=1.
- Preload R2=5, then issue the same ADD while wb writes R2=9 in that cycle: rn_val=9.
- FWD_EN=0, ex_wb_en=1, ex_dest=2, ADD using R2: hazard=1 and a bubble is inserted. With ex_dest changed to 4, hazard=0 and the ADD loads next cycle.
- MOVEQ R0,#1 (0x03A00001) with Z=0: out_valid=1, ctrl=0. With Z=1: ctrl exe_cmd=0001, wb_en=1.
- FWD_EN=1, ex_mem_r=1, ex_dest=2 with a STR using R2 as src2: hazard=1. With flush=1 in the same cycle: bubble, out_valid=0.
